// File: rtl/reg_file_wb.sv
// reg_file_wb: 32-entry register file fed by write-back, with two combinational
// read ports, same-cycle write-back bypass and a per-register pending-write
// scoreboard used by decode for read-after-write hazard detection.
// Register 0 reads as zero, ignores writes and is never reported busy.
module reg_file_wb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  // Write-back commit port
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic              regWrite_ctrl,
  // Decode read ports
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  // Scoreboard
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              sb_err
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;
  localparam int unsigned CntW    = 2;
  localparam logic [CntW-1:0] CntMax = '1;

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [CntW-1:0]   cnt_q  [NumRegs];
  logic [CntW-1:0]   cnt_d  [NumRegs];
  logic              sb_err_q;
  logic              err_set;

  logic [NumRegs-1:0] inc_vec;
  logic [NumRegs-1:0] dec_vec;

  logic wr_en;
  logic rs_hit;
  logic rt_hit;

  // Register 0 is excluded from commits so it stays zero forever.
  assign wr_en = regWrite_ctrl && (wb_dest != '0);

  // Decode issue/retire strobes per register; entry 0 never moves.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < NumRegs; r++) begin
      inc_vec[r] = issue_valid && (issue_dest == ADDR_W'(r));
      dec_vec[r] = regWrite_ctrl && (wb_dest == ADDR_W'(r));
    end
  end

  // Next pending counts: saturate at both ends and flag the offending event.
  always_comb begin
    err_set = 1'b0;
    for (int r = 0; r < NumRegs; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    for (int r = 1; r < NumRegs; r++) begin
      unique case ({inc_vec[r], dec_vec[r]})
        2'b10: begin
          if (cnt_q[r] == CntMax) begin
            err_set = 1'b1;
          end else begin
            cnt_d[r] = cnt_q[r] + CntW'(1);
          end
        end
        2'b01: begin
          if (cnt_q[r] == '0) begin
            err_set = 1'b1;
          end else begin
            cnt_d[r] = cnt_q[r] - CntW'(1);
          end
        end
        // Simultaneous issue and retire nets to no change.
        default: cnt_d[r] = cnt_q[r];
      endcase
    end
  end

  // Array, scoreboard and sticky error state; reset discards same-cycle events.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NumRegs; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      if (wr_en) begin
        regs_q[wb_dest] <= wb_data;
      end
      for (int r = 0; r < NumRegs; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      sb_err_q <= sb_err_q | err_set;
    end
  end

  // Bypass hits: the write-back presented this cycle targets the read address.
  assign rs_hit = regWrite_ctrl && (wb_dest == rs_addr) && (rs_addr != '0);
  assign rt_hit = regWrite_ctrl && (wb_dest == rt_addr) && (rt_addr != '0);

  // Read ports with write-back bypass and hazard indication.
  always_comb begin
    rs_data = rs_hit ? wb_data : regs_q[rs_addr];
    rt_data = rt_hit ? wb_data : regs_q[rt_addr];
    // A retiring write is covered by the bypass, so it does not keep the
    // register busy; an underflowing retire (count 0) reads as not busy.
    rs_busy = cnt_q[rs_addr] > {{(CntW-1){1'b0}}, rs_hit};
    rt_busy = cnt_q[rt_addr] > {{(CntW-1){1'b0}}, rt_hit};
  end

  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: hand-computed expectations for reset, bypass,
// register 0, scoreboard counting, saturation/underflow and reset priority.
module tb_reg_file_wb;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] wb_dest;
  logic              regWrite_ctrl;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_dest;
  logic              rs_busy;
  logic              rt_busy;
  logic              sb_err;

  int n_vec;
  int n_err;

  reg_file_wb #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_data      (wb_data),
    .wb_dest      (wb_dest),
    .regWrite_ctrl(regWrite_ctrl),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .issue_valid  (issue_valid),
    .issue_dest   (issue_dest),
    .rs_busy      (rs_busy),
    .rt_busy      (rt_busy),
    .sb_err       (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    regWrite_ctrl = 1'b0;
    issue_valid   = 1'b0;
    wb_data       = '0;
    wb_dest       = '0;
    issue_dest    = '0;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] dest);
    idle();
    issue_valid = 1'b1;
    issue_dest  = dest;
  endtask

  task automatic retire(input logic [ADDR_W-1:0] dest, input logic [DATA_W-1:0] data);
    idle();
    regWrite_ctrl = 1'b1;
    wb_dest       = dest;
    wb_data       = data;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle();
    rs_addr = '0;
    rt_addr = '0;
    rst     = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    rs_addr = 5'd5;
    rt_addr = 5'd31;
    #1;
    check_eq("rst_rs_data", rs_data, 32'h0);
    check_eq("rst_rt_data", rt_data, 32'h0);
    check_eq("rst_rs_busy", {31'h0, rs_busy}, 32'h0);
    check_eq("rst_rt_busy", {31'h0, rt_busy}, 32'h0);
    check_eq("rst_sb_err", {31'h0, sb_err}, 32'h0);

    // r7: issue, then write with same-cycle bypass, then array read
    issue(5'd7);
    tick();
    idle();
    rs_addr = 5'd7;
    rt_addr = 5'd7;
    #1;
    check_eq("r7_busy_after_issue", {31'h0, rs_busy}, 32'h1);
    retire(5'd7, 32'hDEAD_BEEF);
    #1;
    check_eq("r7_bypass_rs", rs_data, 32'hDEAD_BEEF);
    check_eq("r7_bypass_rt", rt_data, 32'hDEAD_BEEF);
    check_eq("r7_busy_retiring", {31'h0, rs_busy}, 32'h0);
    tick();
    idle();
    #1;
    check_eq("r7_array_rs", rs_data, 32'hDEAD_BEEF);
    check_eq("r7_busy_done", {31'h0, rt_busy}, 32'h0);
    check_eq("r7_sb_err", {31'h0, sb_err}, 32'h0);

    // r0: write and issue are both ignored
    retire(5'd0, 32'h1234_5678);
    issue_valid = 1'b1;
    issue_dest  = 5'd0;
    rs_addr     = 5'd0;
    #1;
    check_eq("r0_no_bypass", rs_data, 32'h0);
    check_eq("r0_busy_same", {31'h0, rs_busy}, 32'h0);
    tick();
    idle();
    #1;
    check_eq("r0_read_zero", rs_data, 32'h0);
    check_eq("r0_busy_next", {31'h0, rs_busy}, 32'h0);
    check_eq("r0_sb_err", {31'h0, sb_err}, 32'h0);

    // r3: two issues, two retires
    rs_addr = 5'd3;
    issue(5'd3);
    tick();
    issue(5'd3);
    tick();
    idle();
    tick();
    retire(5'd3, 32'hA);
    #1;
    check_eq("r3_busy_cnt2_ret", {31'h0, rs_busy}, 32'h1);
    check_eq("r3_bypass_a", rs_data, 32'hA);
    tick();
    retire(5'd3, 32'hB);
    #1;
    check_eq("r3_busy_cnt1_ret", {31'h0, rs_busy}, 32'h0);
    check_eq("r3_bypass_b", rs_data, 32'hB);
    tick();
    idle();
    #1;
    check_eq("r3_array_b", rs_data, 32'hB);
    check_eq("r3_busy_idle", {31'h0, rs_busy}, 32'h0);
    check_eq("r3_sb_err", {31'h0, sb_err}, 32'h0);

    // r4: simultaneous issue and retire keeps count 1
    rs_addr = 5'd4;
    rt_addr = 5'd9;
    issue(5'd4);
    tick();
    retire(5'd4, 32'h44);
    issue_valid = 1'b1;
    issue_dest  = 5'd4;
    tick();
    idle();
    #1;
    check_eq("r4_busy_held", {31'h0, rs_busy}, 32'h1);
    check_eq("r4_data", rs_data, 32'h44);
    check_eq("r4_sb_err", {31'h0, sb_err}, 32'h0);

    // Reset with write to r4 and issue of r9 pending: both discarded
    rst = 1'b1;
    retire(5'd4, 32'h99);
    issue_valid = 1'b1;
    issue_dest  = 5'd9;
    tick();
    rst = 1'b0;
    idle();
    #1;
    check_eq("rst_r4_data", rs_data, 32'h0);
    check_eq("rst_r4_busy", {31'h0, rs_busy}, 32'h0);
    check_eq("rst_r9_busy", {31'h0, rt_busy}, 32'h0);
    check_eq("rst_mid_sb_err", {31'h0, sb_err}, 32'h0);
    rs_addr = 5'd7;
    #1;
    check_eq("rst_r7_cleared", rs_data, 32'h0);

    // r9: four issues saturate at 3 and raise sb_err
    rs_addr = 5'd9;
    for (int i = 0; i < 3; i++) begin
      issue(5'd9);
      tick();
    end
    idle();
    #1;
    check_eq("r9_busy_cnt3", {31'h0, rs_busy}, 32'h1);
    check_eq("r9_no_err_yet", {31'h0, sb_err}, 32'h0);
    issue(5'd9);
    tick();
    idle();
    #1;
    check_eq("r9_overflow_err", {31'h0, sb_err}, 32'h1);
    // Three retires drain a saturated count of 3 to zero.
    retire(5'd9, 32'h91);
    #1;
    check_eq("r9_busy_ret1", {31'h0, rs_busy}, 32'h1);
    tick();
    retire(5'd9, 32'h92);
    #1;
    check_eq("r9_busy_ret2", {31'h0, rs_busy}, 32'h1);
    tick();
    retire(5'd9, 32'h93);
    #1;
    check_eq("r9_busy_ret3", {31'h0, rs_busy}, 32'h0);
    tick();
    idle();
    #1;
    check_eq("r9_drained", {31'h0, rs_busy}, 32'h0);
    check_eq("r9_data", rs_data, 32'h93);
    check_eq("r9_err_sticky", {31'h0, sb_err}, 32'h1);

    // r10: retire with count 0 underflows
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("r10_err_cleared", {31'h0, sb_err}, 32'h0);
    retire(5'd10, 32'h10);
    tick();
    idle();
    #1;
    check_eq("r10_underflow_err", {31'h0, sb_err}, 32'h1);
    tick();
    tick();
    check_eq("r10_err_sticky", {31'h0, sb_err}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
# reg_file_wb

Register file at the receiving end of the write-back stage. It accepts the `data_out`/`r_dest` pair produced by write-back and commits it to a 32 x 32-bit register array. It serves two combinational read ports to decode, with same-cycle write-back bypass. It also keeps a per-register pending-write scoreboard so decode can detect read-after-write hazards on instructions still in flight.

## Interface
Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register address width; array depth is 2**ADDR_W

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- wb_data  input  DATA_W  write-back data (driven by write-back `data_out`)
- wb_dest  input  ADDR_W  write-back destination (driven by write-back `r_dest`)
- regWrite_ctrl  input  1  write-back commit enable
- rs_addr  input  ADDR_W  read port A address
- rt_addr  input  ADDR_W  read port B address
- rs_data  output  DATA_W  read port A data
- rt_data  output  DATA_W  read port B data
- issue_valid  input  1  decode issues an instruction that will write issue_dest
- issue_dest  input  ADDR_W  destination of the issued instruction
- rs_busy  output  1  rs_addr has an outstanding write not yet available
- rt_busy  output  1  rt_addr has an outstanding write not yet available
- sb_err  output  1  sticky scoreboard overflow/underflow flag

## Operation
- Register 0 is hardwired to zero:
  - Writes to it are discarded.
  - Reads return 0.
  - Its pending count never changes, and its busy outputs are always 0.
- Write: when regWrite_ctrl=1 and wb_dest!=0, reg[wb_dest] <= wb_data at the clock edge.
- Read: rs_data = (regWrite_ctrl && wb_dest==rs_addr && rs_addr!=0) ? wb_data : reg[rs_addr]. Port B (rt_data) is identical.
- Scoreboard: each register 1..31 has a 2-bit pending count cnt[r].
  - inc = issue_valid && issue_dest==r && r!=0
  - dec = regWrite_ctrl && wb_dest==r && r!=0
  - inc only: cnt+1. If cnt==3, hold at 3 and set sb_err.
  - dec only: cnt-1. If cnt==0, hold at 0 and set sb_err.
  - inc and dec together: cnt unchanged, no error.
- Busy: rs_busy = (cnt[rs_addr] - dec_hit_rs) != 0, where dec_hit_rs = 1 when the current write-back targets rs_addr. A write retiring this cycle is covered by the bypass, so it does not count as busy. rt_busy is computed the same way.
- sb_err, once set, stays 1 until rst.
- Reset: all registers become 0, all counts become 0, sb_err becomes 0. Reset takes priority over write, issue and retire in the same cycle; those events are discarded.

## Timing
- Read ports: zero latency (combinational from addresses, array and write-back inputs).
- Write: visible through the array on the cycle after the edge. It is visible through the bypass in the same cycle it is presented.
- Issue at edge N: busy is asserted for that register from cycle N+1.
- Retire at edge M: busy is deasserted combinationally during cycle M (bypass), and the count is decremented at edge M.
- Reset values of outputs:
  - rs_data = rt_data = 0
  - rs_busy = rt_busy = 0
  - sb_err = 0
- Two writes cannot collide: there is one write port. Issue and retire of the same register in the same cycle is legal and nets to no change.
- Reset asserted mid-operation (counts nonzero, write pending): the next cycle shows the all-zero state, and the discarded retire does not raise sb_err.

## Test plan
- Reset, then read r5 on rs and r31 on rt -> rs_data=0, rt_data=0, busy=0, sb_err=0.
- Write r7=0xDEADBEEF with rs_addr=7 in the same cycle -> rs_data=0xDEADBEEF that cycle (bypass) and on the following cycle from the array.
- Write r0=0x12345678 and issue r0 -> rs_addr=0 reads 0, rs_busy=0, sb_err=0.
- Issue r3 twice (cycles 1,2), retire r3 with 0xA in cycle 4 -> rs_busy=1 in cycle 4 (count 2→1). Retire 0xB in cycle 5 -> rs_busy=0 in cycle 5, rs_data=0xB.
- Issue r9 four times with no retire -> cnt saturates at 3 and sb_err=1 from the cycle after the 4th issue. Retire r10 with cnt[r10]=0 after reset -> sb_err=1.
- With cnt[r4]=1, assert issue r4 and retire r4 together -> count stays 1, rs_busy stays 1. Assert rst with a write to r4 -> r4=0, cnt=0, sb_err=0 next cycle.
